// File: rtl/cavlc_chroma_dc_scan_pkg.sv
// Shared definitions for the CAVLC chroma DC scan stage and the
// nC = -1 coeff_token lookup that consumes its table address.
package cavlc_chroma_dc_scan_pkg;

    localparam int CDC_NUM_COEFF = 4;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } cdc_state_e;

    // Table row is TotalCoeff-1; TotalCoeff==4 wraps to row 3.
    function automatic logic [3:0] ct_pack(
        input logic [2:0] tc,
        input logic [1:0] t1
    );
        return (tc == 3'd0) ? 4'd0 : {tc[1:0] - 2'd1, t1};
    endfunction

endpackage

// File: rtl/cavlc_chroma_dc_scan_classify.sv
// Per-coefficient decision: nonzero, and whether it extends the
// run of trailing +/-1 values.
module cavlc_chroma_dc_scan_classify #(
    parameter int LEVEL_W = 16
) (
    input  logic [LEVEL_W-1:0] coeff_i,
    input  logic               open_i,
    input  logic [1:0]         t1_cnt_i,
    output logic               is_nz_o,
    output logic               is_t1_o
);

    logic is_one;

    assign is_nz_o = (coeff_i != '0);
    assign is_one  = (coeff_i == LEVEL_W'(1))
                  || (coeff_i == {LEVEL_W{1'b1}});
    assign is_t1_o = is_nz_o && open_i && is_one
                  && (t1_cnt_i != 2'd3);

endmodule

// File: rtl/cavlc_chroma_dc_scan.sv
// Collects a 2x2 chroma DC block, reverse-scans it one coefficient
// per cycle and holds the CAVLC statistics until accepted.
module cavlc_chroma_dc_scan
    import cavlc_chroma_dc_scan_pkg::*;
#(
    parameter int LEVEL_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LEVEL_W-1:0]     in_coeff,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             ct_addr,
    output logic                   ct_zero,
    output logic [2:0]             total_coeff,
    output logic [1:0]             trailing_ones,
    output logic [2:0]             t1_signs,
    output logic [1:0]             total_zeros,
    output logic [4*LEVEL_W-1:0]   levels,
    output logic [7:0]             runs
);

    cdc_state_e state_q, state_d;

    logic [LEVEL_W-1:0] coef_q [CDC_NUM_COEFF];
    logic [LEVEL_W-1:0] coef_d [CDC_NUM_COEFF];
    logic [LEVEL_W-1:0] lev_q  [CDC_NUM_COEFF];
    logic [LEVEL_W-1:0] lev_d  [CDC_NUM_COEFF];
    logic [1:0]         run_q  [CDC_NUM_COEFF];
    logic [1:0]         run_d  [CDC_NUM_COEFF];

    logic [1:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] t1_q, t1_d;
    logic [1:0] zrun_q, zrun_d;
    logic [2:0] tc_q, tc_d;
    logic [2:0] sgn_q, sgn_d;
    logic       open_q, open_d;
    logic       zero_q, zero_d;

    logic               accept;
    logic               is_nz;
    logic               is_t1;
    logic [LEVEL_W-1:0] cur;

    assign accept = in_valid && in_ready;
    assign cur    = coef_q[idx_q];

    cavlc_chroma_dc_scan_classify #(
        .LEVEL_W (LEVEL_W)
    ) u_classify (
        .coeff_i  (cur),
        .open_i   (open_q),
        .t1_cnt_i (t1_q),
        .is_nz_o  (is_nz),
        .is_t1_o  (is_t1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_LOAD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: if (accept && cnt_q == 2'd3) state_d = ST_SCAN;
            ST_SCAN: if (idx_q == 2'd0)           state_d = ST_DONE;
            ST_DONE: if (out_ready)               state_d = ST_LOAD;
            default:                              state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_LOAD: in_ready  = rst_n;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        coef_d = coef_q;
        lev_d  = lev_q;
        run_d  = run_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        t1_d   = t1_q;
        zrun_d = zrun_q;
        tc_d   = tc_q;
        sgn_d  = sgn_q;
        open_d = open_q;
        zero_d = zero_q;
        if (accept) begin
            coef_d[cnt_q] = in_coeff;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                idx_d  = 2'd3;
                lev_d  = '{default: '0};
                run_d  = '{default: '0};
                t1_d   = '0;
                zrun_d = '0;
                tc_d   = '0;
                sgn_d  = '0;
                open_d = 1'b1;
                zero_d = 1'b0;
            end
        end
        if (state_q == ST_SCAN) begin
            idx_d = idx_q - 2'd1;
            if (!is_nz) begin
                if (tc_q != 3'd0) zrun_d = zrun_q + 2'd1;
            end else begin
                if (is_t1) begin
                    sgn_d[t1_q] = cur[LEVEL_W-1];
                    t1_d = t1_q + 2'd1;
                end else begin
                    open_d = 1'b0;
                end
                lev_d[tc_q[1:0]] = cur;
                if (tc_q != 3'd0) run_d[tc_q[1:0] - 2'd1] = zrun_q;
                zrun_d = '0;
                tc_d = tc_q + 3'd1;
            end
            // Zeros below the lowest-frequency nonzero close the last run.
            if (idx_q == 2'd0) begin
                if (tc_d != 3'd0) run_d[tc_d[1:0] - 2'd1] = zrun_d;
                zero_d = (tc_d == 3'd0);
            end
        end
        if (out_valid && out_ready) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coef_q <= '{default: '0};
            lev_q  <= '{default: '0};
            run_q  <= '{default: '0};
            cnt_q  <= '0;
            idx_q  <= '0;
            t1_q   <= '0;
            zrun_q <= '0;
            tc_q   <= '0;
            sgn_q  <= '0;
            open_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            coef_q <= coef_d;
            lev_q  <= lev_d;
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            t1_q   <= t1_d;
            zrun_q <= zrun_d;
            tc_q   <= tc_d;
            sgn_q  <= sgn_d;
            open_q <= open_d;
            zero_q <= zero_d;
        end
    end

    assign ct_addr       = ct_pack(tc_q, t1_q);
    assign ct_zero       = zero_q;
    assign total_coeff   = tc_q;
    assign trailing_ones = t1_q;
    assign t1_signs      = sgn_q;
    assign total_zeros   = run_q[0] + run_q[1] + run_q[2] + run_q[3];
    assign levels        = {lev_q[3], lev_q[2], lev_q[1], lev_q[0]};
    assign runs          = {run_q[3], run_q[2], run_q[1], run_q[0]};

endmodule

// File: tb/tb_cavlc_chroma_dc_scan.sv
// Randomised bench for cavlc_chroma_dc_scan against a list-based
// model of the reverse scan, plus directed corner blocks.
module tb_cavlc_chroma_dc_scan;

    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LW-1:0] in_coeff = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    ct_addr;
    logic          ct_zero;
    logic [2:0]    total_coeff;
    logic [1:0]    trailing_ones;
    logic [2:0]    t1_signs;
    logic [1:0]    total_zeros;
    logic [4*LW-1:0] levels;
    logic [7:0]    runs;

    typedef struct {
        int tc;
        int t1;
        int signs;
        int tz;
        int addr;
        int zero;
        logic [4*LW-1:0] lev;
        logic [7:0] runs;
    } exp_t;

    exp_t expq[$];
    int   nvec = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   acc4_cyc = 0;
    bit   force_low = 1'b0;

    cavlc_chroma_dc_scan #(.LEVEL_W(LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_coeff      (in_coeff),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ct_addr       (ct_addr),
        .ct_zero       (ct_zero),
        .total_coeff   (total_coeff),
        .trailing_ones (trailing_ones),
        .t1_signs      (t1_signs),
        .total_zeros   (total_zeros),
        .levels        (levels),
        .runs          (runs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Nonzero positions in reverse scan order drive everything.
    function automatic exp_t model(input logic [63:0] blk);
        exp_t e;
        int pos[$];
        logic signed [LW-1:0] v;
        e = '{default: 0};
        e.lev = '0;
        e.runs = '0;
        for (int i = 3; i >= 0; i--)
            if (blk[i*LW +: LW] != '0) pos.push_back(i);
        e.tc = pos.size();
        for (int k = 0; k < e.tc; k++) begin
            e.lev[k*LW +: LW] = blk[pos[k]*LW +: LW];
            if (k == e.tc - 1) e.runs[k*2 +: 2] = 2'(pos[k]);
            else e.runs[k*2 +: 2] = 2'(pos[k] - pos[k+1] - 1);
        end
        for (int k = 0; k < e.tc && e.t1 < 3; k++) begin
            v = blk[pos[k]*LW +: LW];
            if (v == 1 || v == -1) begin
                if (v < 0) e.signs = e.signs | (1 << e.t1);
                e.t1++;
            end else begin
                break;
            end
        end
        e.tz   = (e.tc == 0) ? 0 : pos[0] + 1 - e.tc;
        e.addr = (e.tc == 0) ? 0 : (e.tc - 1) * 4 + e.t1;
        e.zero = (e.tc == 0) ? 1 : 0;
        return e;
    endfunction

    function automatic logic [LW-1:0] rnd_coef();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 3) return '0;
        if (r <= 5) return 16'd1;
        if (r == 6) return 16'hFFFF;
        if (r == 7) return 16'($urandom_range(2, 5)) * (($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'd1);
        if (r == 8) return 16'($urandom);
        return ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
    endfunction

    task automatic send_block(input logic [63:0] blk);
        for (int i = 0; i < 4; i++) begin
            int budget;
            bit ok;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_coeff = 16'($urandom);
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_coeff = blk[i*LW +: LW];
            ok = 1'b0;
            budget = 0;
            while (!ok && budget < 200) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!ok) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            if (i == 3) begin
                acc4_cyc = cyc;
                expq.push_back(model(blk));
            end
        end
        in_valid = 1'b0;
        in_coeff = 16'($urandom);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while ((expq.size() != 0 || out_valid) && budget < 300);
        chk("idle_timeout", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = force_low ? 1'b0 : ($urandom_range(0, 9) < 7);
        end
    end

    initial begin
        bit prev_ov;
        bit prev_hs;
        exp_t e;
        prev_ov = 1'b0;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) chk("in_ready_after_hs", 64'(in_ready), 64'd1);
                if (prev_ov && !prev_hs)
                    chk("out_valid_hold", 64'(out_valid), 64'd1);
                if (out_valid) begin
                    chk("in_ready_busy", 64'(in_ready), 64'd0);
                    if (!prev_ov)
                        chk("latency", 64'(cyc), 64'(acc4_cyc + 4));
                    if (expq.size() == 0) begin
                        chk("unexpected_valid", 64'(out_valid), 64'd0);
                    end else begin
                        e = expq[0];
                        chk("total_coeff", 64'(total_coeff), 64'(e.tc));
                        chk("trailing_ones", 64'(trailing_ones), 64'(e.t1));
                        chk("t1_signs", 64'(t1_signs), 64'(e.signs));
                        chk("total_zeros", 64'(total_zeros), 64'(e.tz));
                        chk("ct_addr", 64'(ct_addr), 64'(e.addr));
                        chk("ct_zero", 64'(ct_zero), 64'(e.zero));
                        chk("levels", levels, e.lev);
                        chk("runs", 64'(runs), 64'(e.runs));
                    end
                end
                prev_hs = out_valid && out_ready;
                if (prev_hs && expq.size() > 0) void'(expq.pop_front());
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t m;
        int budget;

        m = model(pk(3, 0, -1, 1));
        chk("pin_a_tc", 64'(m.tc), 64'd3);
        chk("pin_a_t1", 64'(m.t1), 64'd2);
        chk("pin_a_signs", 64'(m.signs), 64'b010);
        chk("pin_a_addr", 64'(m.addr), 64'd10);
        chk("pin_a_lev", m.lev, 64'h0000_0003_FFFF_0001);
        chk("pin_a_runs", 64'(m.runs), 64'h04);
        chk("pin_a_tz", 64'(m.tz), 64'd1);
        m = model(pk(1, 1, 1, 1));
        chk("pin_b_addr", 64'(m.addr), 64'd15);
        chk("pin_b_lev", m.lev, 64'h0001_0001_0001_0001);
        m = model(pk(0, 0, 0, -5));
        chk("pin_c_lev", m.lev, 64'h0000_0000_0000_FFFB);
        chk("pin_c_runs", 64'(m.runs), 64'h03);
        chk("pin_c_tz", 64'(m.tz), 64'd3);
        m = model(pk(0, 0, 0, 0));
        chk("pin_d_zero", 64'(m.zero), 64'd1);
        m = model(pk(2, -1, 1, 1));
        chk("pin_e_t1", 64'(m.t1), 64'd3);
        chk("pin_e_signs", 64'(m.signs), 64'b100);
        chk("pin_e_addr", 64'(m.addr), 64'd15);
        m = model(pk(0, 0, 1, 0));
        chk("pin_f_addr", 64'(m.addr), 64'd1);
        chk("pin_f_tz", 64'(m.tz), 64'd2);

        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
        end
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_total_coeff", 64'(total_coeff), 64'd0);
        chk("rst_ct_zero", 64'(ct_zero), 64'd0);
        chk("rst_levels", levels, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        send_block(pk(3, 0, -1, 1));
        send_block(pk(1, 1, 1, 1));
        send_block(pk(0, 0, 0, -5));
        send_block(pk(0, 0, 0, 0));

        wait_idle();
        @(posedge clk);
        #1;
        force_low = 1'b1;
        send_block(pk(2, -1, 1, 1));
        budget = 0;
        while (!out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        repeat (5) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        force_low = 1'b0;

        wait_idle();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_coeff = 16'd7;
        @(posedge clk);
        #1;
        in_coeff = 16'hFFFD;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_total_coeff", 64'(total_coeff), 64'd0);
        chk("mid_rst_ct_addr", 64'(ct_addr), 64'd0);
        chk("mid_rst_levels", levels, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send_block(pk(0, 0, 1, 0));

        for (int n = 0; n < 300; n++) begin
            logic [63:0] blk;
            for (int j = 0; j < 4; j++) blk[j*LW +: LW] = rnd_coef();
            send_block(blk);
        end

        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
